instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Parametrised instruction memory for the MIPS core, with a built-in program loader.
- Run mode: serves registered word fetches addressed by the PC (byte address).
- Load mode: a byte-stream handshake from the debug unit assembles big-endian words and writes them sequentially from address 0.
- Load ends on a halt word or when memory is full.
- Replaces direct Wr/Addr/In_Data poking of the memory.

Parameters:
DATA_W, 32, instruction width in bits; must be a multiple of 8; BPW = DATA_W/8 bytes per word.
ADDR_W, 11, word-address width; DEPTH = 2**ADDR_W words.
HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is written to memory, then the load terminates.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  pulse; begins a load at word 0
in_byte  in  8  loader data byte
in_valid  in  1  in_byte valid
in_ready  out  1  loader accepts a byte this cycle
load_busy  out  1  FSM in LOAD
load_done  out  1  one-cycle pulse when a load completes
load_count  out  ADDR_W+1  words written by the last or current load
fetch_en  in  1  fetch request
fetch_addr  in  32  PC byte address
instr  out  DATA_W  fetched instruction
instr_valid  out  1  instr is valid for the request made the previous cycle
addr_err  out  1  previous fetch was misaligned or out of range

Behaviour:
- Reset values:
  - FSM = IDLE.
  - in_ready, load_busy, load_done, instr_valid, addr_err = 0.
  - instr = 0, load_count = 0.
  - Byte lane counter = 0, write pointer = 0.
  - Memory contents are NOT cleared.
- FSM states: IDLE, LOAD, FINISH.
  - IDLE -> LOAD on load_start. Clears write pointer, byte lane, load_count.
  - LOAD -> FINISH when a completed word equals HALT_WORD, or when the word written is at address DEPTH-1.
  - FINISH -> IDLE unconditionally after 1 cycle; load_done = 1 only in FINISH.
- In LOAD: in_ready = 1 and load_busy = 1; in IDLE and FINISH both are 0.
- Byte accept rule: a byte is accepted iff in_valid && in_ready.
  - First accepted byte goes to bits [DATA_W-1:DATA_W-8] (big-endian).
  - On acceptance of byte BPW-1, the assembled word is written to mem[wr_ptr] at that edge; wr_ptr and load_count increment; the lane returns to 0.
- Ignored inputs:
  - in_valid outside LOAD.
  - load_start while in LOAD or FINISH.
- Fetch (served in IDLE only):
  - Word index = fetch_addr[ADDR_W+1:2].
  - Read latency is 1 cycle: instr and instr_valid are registered.
  - addr_err = 1, instr = 0 (NOP), instr_valid = 1 when either:
    - fetch_addr[1:0] != 0, or
    - any bit of fetch_addr[31:ADDR_W+2] is set.
- Fetch in LOAD or FINISH, or fetch_en = 0: next cycle instr_valid = 0, addr_err = 0, instr holds its previous value.
- load_start and fetch_en in the same IDLE cycle: load wins; the fetch is dropped (instr_valid = 0 next cycle).
- Reset mid-load:
  - Partial word is discarded; FSM returns to IDLE; load_count = 0.
  - Words already written remain in memory.
- load_count holds its value after FINISH until the next load_start.

Optional Feature:
INSTR_MEM_CHECKSUM_EN
- Defined: adds output port load_csum, 8 bits.
  - Running XOR of every accepted byte, including the halt-word bytes.
  - Cleared on reset and on a load_start accepted in IDLE.
  - Held after FINISH.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Case 1 (load + fetch):
  - Stimulus: reset; load_start; stream bytes ac 03 00 00, 00 42 38 21, 00 23 10 23, ff ff ff ff.
  - Response: load_done pulses once, load_count = 4.
  - Then fetch 0, 4, 8 back-to-back -> instr = 0xac030000, 0x00423821, 0x00231023 one cycle after each request, instr_valid = 1.
- Case 2 (bad address): fetch_addr = 6 -> addr_err = 1, instr = 0, instr_valid = 1. Repeat with fetch_addr = 0x00010000 (ADDR_W = 11) -> same response.
- Case 3 (stray bytes): after Case 1, drive in_valid = 1 with byte 0x55 in IDLE for 4 cycles -> in_ready = 0; fetch 0 still returns 0xac030000.
- Case 4 (reset mid-load): load_start; send bytes 11 22; assert reset -> in_ready = 0, load_busy = 0, load_count = 0; fetch 0 returns the previous 0xac030000.
- Case 5 (memory full): ADDR_W = 2 (DEPTH = 4); load 4 non-halt words 0x00000001..0x00000004 -> load_done after 4th word; next byte not accepted (in_ready = 0); fetch 12 -> 0x00000004.
- Case 6 (checksum, macro defined): load ac 03 00 00 ff ff ff ff -> load_csum = 0xaf; a new load_start clears it to 0x00.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream program loader (big-endian word assembly).
// Optional load checksum port enabled by defining INSTR_MEM_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 11,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
`ifdef INSTR_MEM_CHECKSUM_EN
  output logic [7:0]        load_csum,
`endif
  output logic [1:0]        state_dbg
);
  localparam int BPW    = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FINISH = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                addr_err_q, addr_err_d;
  logic [7:0]          csum_q, csum_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [DATA_W-1:0]   assembled;
  logic                byte_acc;
  logic                fetch_ok;
  logic                addr_bad;

  // Handshake: a byte moves when in_valid && in_ready on a rising edge;
  // in_ready depends only on state, never on in_valid.
  assign in_ready  = (state_q == S_LOAD);
  assign load_busy = (state_q == S_LOAD);
  assign load_done = (state_q == S_FINISH);
  assign state_dbg = state_q;

  assign byte_acc  = in_valid && in_ready;
  assign assembled = (word_q << 8) | DATA_W'(in_byte);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    word_d       = word_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    csum_d       = csum_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d      = S_LOAD;
          lane_d       = '0;
          wr_ptr_d     = '0;
          load_count_d = '0;
          csum_d       = '0;
        end
      end
      S_LOAD: begin
        if (byte_acc) begin
          word_d = assembled;
          csum_d = csum_q ^ in_byte;
          if (lane_q == LANE_W'(BPW - 1)) begin
            mem_we       = 1'b1;
            lane_d       = '0;
            wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
            load_count_d = load_count_q + (ADDR_W + 1)'(1);
            if (assembled == HALT_WORD || wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
              state_d = S_FINISH;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A simultaneous load_start takes priority and drops the fetch.
  always_comb begin
    fetch_ok      = (state_q == S_IDLE) && fetch_en && !load_start;
    addr_bad      = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (ADDR_W + 2)) != 32'd0);
    instr_valid_d = fetch_ok;
    addr_err_d    = fetch_ok && addr_bad;
    instr_d       = instr_q;
    if (fetch_ok) begin
      instr_d = addr_bad ? '0 : mem[fetch_addr[ADDR_W+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= assembled;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lane_q        <= '0;
      word_q        <= '0;
      wr_ptr_q      <= '0;
      load_count_q  <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      csum_q        <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      wr_ptr_q      <= wr_ptr_d;
      load_count_q  <= load_count_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      addr_err_q    <= addr_err_d;
      csum_q        <= csum_d;
    end
  end

  assign load_count  = load_count_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign addr_err    = addr_err_q;
`ifdef INSTR_MEM_CHECKSUM_EN
  assign load_csum   = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: byte-queue reference model checked every cycle,
// directed cases with literal expectations, then randomized loads and fetches.
module tb_instr_mem_loader;
  localparam int          ADDR_W = 11;
  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam int          BPW    = 4;
  localparam logic [31:0] HALT   = 32'hFFFFFFFF;

  logic        clk, reset, load_start, in_valid, fetch_en;
  logic [7:0]  in_byte;
  logic [31:0] fetch_addr;
  logic        in_ready, load_busy, load_done, instr_valid, addr_err;
  logic [ADDR_W:0] load_count;
  logic [31:0] instr;
  logic [1:0]  state_dbg;
`ifdef INSTR_MEM_CHECKSUM_EN
  logic [7:0]  load_csum;
`endif

  instr_mem_loader #(.DATA_W(32), .ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .load_busy(load_busy),
    .load_done(load_done), .load_count(load_count), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .instr(instr), .instr_valid(instr_valid),
    .addr_err(addr_err),
`ifdef INSTR_MEM_CHECKSUM_EN
    .load_csum(load_csum),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 loading, 2 finishing
  int          m_mode = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_mem[DEPTH];
  int          m_count = 0;
  int          m_ptr = 0;
  logic        e_valid = 0, e_err = 0;
  logic [31:0] e_instr = 0;
  logic [7:0]  m_csum = 0;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_bytes.delete(); m_count = 0; m_ptr = 0;
      e_valid = 0; e_err = 0; e_instr = 0; m_csum = 0;
    end else begin
      if (m_mode == 0 && fetch_en && !load_start) begin
        e_valid = 1;
        if (fetch_addr % 4 != 0 || fetch_addr >= 32'(DEPTH * 4)) begin
          e_err = 1; e_instr = 0;
        end else begin
          e_err = 0; e_instr = m_mem[fetch_addr / 4];
        end
      end else begin
        e_valid = 0; e_err = 0;
      end
      case (m_mode)
        0: if (load_start) begin
          m_mode = 1; m_bytes.delete(); m_count = 0; m_ptr = 0; m_csum = 0;
        end
        1: if (in_valid) begin
          m_bytes.push_back(in_byte);
          m_csum = m_csum ^ in_byte;
          if (m_bytes.size() == BPW) begin
            m_word = 0;
            foreach (m_bytes[i]) m_word = m_word * 256 + 32'(m_bytes[i]);
            m_mem[m_ptr] = m_word;
            m_ptr++; m_count++;
            m_bytes.delete();
            if (m_word == HALT || m_ptr == DEPTH) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",    32'(in_ready),    32'(m_mode == 1));
      chk("load_busy",   32'(load_busy),   32'(m_mode == 1));
      chk("load_done",   32'(load_done),   32'(m_mode == 2));
      chk("load_count",  32'(load_count),  32'(m_count));
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("addr_err",    32'(addr_err),    32'(e_err));
      chk("instr",       instr,            e_instr);
`ifdef INSTR_MEM_CHECKSUM_EN
      chk("load_csum",   32'(load_csum),   32'(m_csum));
`endif
    end
  end

  // driver tasks: each is entered and left at a falling edge
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
      1:       return {$urandom_range(0, DEPTH - 1), 2'b00} | (32'd1 << $urandom_range(13, 31));
      default: return 32'({$urandom_range(0, DEPTH - 1), 2'b00});
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit noise);
    if (noise) begin
      while ($urandom_range(0, 3) == 0) begin
        in_byte = 8'($urandom); fetch_en = 1'($urandom); fetch_addr = rand_addr();
        step();
      end
      fetch_en = 1'($urandom); fetch_addr = rand_addr();
      load_start = ($urandom_range(0, 7) == 0);
    end
    in_valid = 1; in_byte = b;
    step();
    in_valid = 0; fetch_en = 0; load_start = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit noise);
    for (int i = 0; i < BPW; i++) send_byte(w[31 - 8 * i -: 8], noise);
  endtask

  task automatic start_load();
    load_start = 1;
    step();
    load_start = 0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    fetch_en = 1; fetch_addr = a;
    step();
    fetch_en = 0;
  endtask

  logic [31:0] w, last_w;

  initial begin
    reset = 1; load_start = 0; in_valid = 0; in_byte = 0; fetch_en = 0; fetch_addr = 0;
    step(); step();
    chk_en = 1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_count", 32'(load_count), 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    reset = 0;
    step();

    // load a short program ending with the halt word, then fetch it back
    start_load();
    send_word(32'hac030000, 0); send_word(32'h00423821, 0);
    send_word(32'h00231023, 0); send_word(HALT, 0);
    chk("c1_done", 32'(load_done), 1);
    chk("c1_count", 32'(load_count), 4);
    step(); step();
    fetch_en = 1; fetch_addr = 0; step();
    fetch_addr = 4; chk("c1_f0", instr, 32'hac030000); chk("c1_v0", 32'(instr_valid), 1); step();
    fetch_addr = 8; chk("c1_f4", instr, 32'h00423821); step();
    fetch_en = 0;   chk("c1_f8", instr, 32'h00231023); step();
    chk("c1_idle_valid", 32'(instr_valid), 0);
    chk("c1_hold", instr, 32'h00231023);
    chk("c1_count_hold", 32'(load_count), 4);

    // misaligned and out-of-range fetches
    fetch1(32'd6);
    chk("c2_err6", 32'(addr_err), 1); chk("c2_instr6", instr, 0); chk("c2_v6", 32'(instr_valid), 1);
    fetch1(32'h00010000);
    chk("c2_err_hi", 32'(addr_err), 1); chk("c2_instr_hi", instr, 0);

    // stray bytes in idle
    in_valid = 1; in_byte = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk("c3_ready", 32'(in_ready), 0);
      step();
    end
    in_valid = 0;
    fetch1(0);
    chk("c3_f0", instr, 32'hac030000);

    // reset part-way through a word
    start_load();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset = 1; step();
    chk("c4_ready", 32'(in_ready), 0); chk("c4_busy", 32'(load_busy), 0);
    chk("c4_count", 32'(load_count), 0);
    reset = 0;
    fetch1(0);
    chk("c4_f0", instr, 32'hac030000);

`ifdef INSTR_MEM_CHECKSUM_EN
    start_load();
    send_word(32'hac030000, 0); send_word(HALT, 0);
    chk("c6_csum", 32'(load_csum), 32'haf);
    step(); step();
    chk("c6_csum_hold", 32'(load_csum), 32'haf);
    start_load();
    chk("c6_csum_clr", 32'(load_csum), 0);
    send_word(HALT, 0);
    step(); step();
`endif

    // load_start and fetch in the same idle cycle
    fetch_en = 1; fetch_addr = 0; load_start = 1; step();
    fetch_en = 0; load_start = 0;
    chk("col_valid", 32'(instr_valid), 0); chk("col_busy", 32'(load_busy), 1);
    send_word(HALT, 0);
    step(); step();

    // fill every word without a halt: load ends on the last address
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      do w = $urandom; while (w == HALT);
      send_word(w, 0);
      last_w = w;
    end
    chk("full_done", 32'(load_done), 1);
    chk("full_count", 32'(load_count), DEPTH);
    step();
    send_byte(8'h5a, 0);
    chk("full_ready", 32'(in_ready), 0);
    fetch1(32'(DEPTH * 4 - 4));
    chk("full_last", instr, last_w);
    fetch1(32'(DEPTH * 4));
    chk("full_oob", 32'(addr_err), 1);

    // randomized mix of fetches, loads with noise, and mid-load resets
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          fetch_en = 1'($urandom_range(0, 3) != 0); fetch_addr = rand_addr();
          step();
          fetch_en = 0;
        end
        3, 4: begin
          start_load();
          for (int k = $urandom_range(0, 4); k > 0; k--) send_word($urandom, 1);
          send_word(HALT, 1);
          step();
        end
        default: begin
          start_load();
          for (int k = $urandom_range(1, 6); k > 0; k--) send_byte(8'($urandom), 1);
          reset = 1; step();
          reset = 0;
        end
      endcase
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end
endmodule
